// File: rtl/axis_bit_corr_prog.sv
// axis_bit_corr_prog: runtime-programmable multi-channel +/-1 bit correlator.
// One transposed-form adder chain is shared across all channels, processing
// one channel per clock. Partial sums are stored per tap and per channel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_t*           input beat, NUM_CHANNELS signed samples
//   m_axis_t*           registered result beat; tuser bit c flags |y_c| >= threshold
//   coef_wr/coef_data   load a new sign pattern (applied at the next accepted beat)
//   threshold           unsigned detection threshold
//   clear               request a sweep that zeroes all correlation history
module axis_bit_corr_prog #(
   parameter int unsigned NUM_CHANNELS = 8,
   parameter int unsigned SAMPLE_WIDTH = 8,
   parameter int unsigned CORR_LENGTH  = 32,
   parameter int unsigned ADDER_WIDTH  = 14,
   parameter int unsigned OUT_WIDTH    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_axis_tdata,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [NUM_CHANNELS*OUT_WIDTH-1:0]    m_axis_tdata,
   output logic [NUM_CHANNELS-1:0]              m_axis_tuser,
   input  logic                                 coef_wr,
   input  logic [CORR_LENGTH-1:0]               coef_data,
   input  logic [ADDER_WIDTH-1:0]               threshold,
   input  logic                                 clear
);

   localparam int unsigned CH_W = $clog2(NUM_CHANNELS);
   localparam int unsigned NT   = CORR_LENGTH - 1;   // stored partial-sum stages
   localparam int unsigned AW1  = ADDER_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, PROC, HOLD, CLEAR} state_e;

   state_e                               state_q, state_d;
   logic [CH_W-1:0]                      ch_q, ch_d;
   logic                                 clear_pend_q, clear_pend_d;
   logic                                 tready_q, tready_d;
   logic                                 coef_pend_q;
   logic [CORR_LENGTH-1:0]               coef_shadow_q;
   logic [CORR_LENGTH-1:0]               pattern_q;
   logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] x_q;
   logic                                 m_tvalid_q;
   logic [NUM_CHANNELS*OUT_WIDTH-1:0]    m_tdata_q;
   logic [NUM_CHANNELS-1:0]              m_tuser_q;

   logic signed [ADDER_WIDTH-1:0]        ps_q [NT][NUM_CHANNELS];
   logic signed [OUT_WIDTH-1:0]          res_y_q [NUM_CHANNELS];
   logic                                 res_f_q [NUM_CHANNELS];

   logic signed [SAMPLE_WIDTH-1:0]       samp_c [NUM_CHANNELS];
   logic signed [SAMPLE_WIDTH-1:0]       x_sel_c;
   logic signed [ADDER_WIDTH-1:0]        x_pos_c, x_neg_c;
   logic signed [ADDER_WIDTH-1:0]        prod_c [CORR_LENGTH];
   logic signed [ADDER_WIDTH-1:0]        ps_next_c [NT];
   logic signed [ADDER_WIDTH-1:0]        y_c;
   logic signed [AW1-1:0]                y_wide_c;
   logic [AW1-1:0]                       y_abs_c;
   logic                                 flag_c;
   logic signed [OUT_WIDTH-1:0]          y_out_c;
   logic [NUM_CHANNELS*OUT_WIDTH-1:0]    out_data_c;
   logic [NUM_CHANNELS-1:0]              out_user_c;
   logic                                 accept_c, load_out_c, last_ch_c, out_free_c;

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tuser  = m_tuser_q;

   // Unpack the captured beat into per-channel samples
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_samp
      assign samp_c[c] = x_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   end

   // Shared datapath for the channel selected by ch_q
   always_comb begin
      x_sel_c = samp_c[ch_q];
      x_pos_c = ADDER_WIDTH'(x_sel_c);
      x_neg_c = -x_pos_c;
      for (int k = 0; k < CORR_LENGTH; k++) begin
         prod_c[k] = pattern_q[k] ? x_pos_c : x_neg_c;
      end
      for (int n = 0; n < NT; n++) begin
         if (n == NT - 1) ps_next_c[n] = prod_c[n+1];
         else             ps_next_c[n] = prod_c[n+1] + ps_q[n+1][ch_q];
      end
      y_c      = prod_c[0] + ps_q[0][ch_q];
      // One extra bit so the most-negative sum has a representable magnitude
      y_wide_c = AW1'(y_c);
      y_abs_c  = y_wide_c[AW1-1] ? AW1'(-y_wide_c) : AW1'(y_wide_c);
      flag_c   = (y_abs_c >= {1'b0, threshold});
      y_out_c  = OUT_WIDTH'(y_c);
   end

   // Output load source: result buffer, with the channel being computed right now bypassed in
   always_comb begin
      out_data_c = '0;
      out_user_c = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (state_q == PROC && ch_q == CH_W'(c)) begin
            out_data_c[c*OUT_WIDTH +: OUT_WIDTH] = y_out_c;
            out_user_c[c]                        = flag_c;
         end else begin
            out_data_c[c*OUT_WIDTH +: OUT_WIDTH] = res_y_q[c];
            out_user_c[c]                        = res_f_q[c];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      clear_pend_d = clear_pend_q | clear;
      accept_c     = 1'b0;
      load_out_c   = 1'b0;
      last_ch_c    = (ch_q == CH_W'(NUM_CHANNELS - 1));
      out_free_c   = !m_tvalid_q || m_axis_tready;
      case (state_q)
         IDLE: begin
            if (clear_pend_q) begin
               state_d      = CLEAR;
               ch_d         = '0;
               clear_pend_d = 1'b0;
            end else if (s_axis_tvalid && tready_q) begin
               accept_c = 1'b1;
               state_d  = PROC;
               ch_d     = '0;
            end
         end
         PROC: begin
            ch_d = ch_q + CH_W'(1);
            if (last_ch_c) begin
               ch_d = '0;
               if (out_free_c) begin
                  load_out_c = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (m_axis_tready) begin
               load_out_c = 1'b1;
               state_d    = IDLE;
            end
         end
         CLEAR: begin
            ch_d = ch_q + CH_W'(1);
            if (last_ch_c) begin
               ch_d    = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      tready_d = (state_d == IDLE) && !clear_pend_d;
   end

   // Control, pattern and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         clear_pend_q  <= 1'b0;
         tready_q      <= 1'b0;
         coef_pend_q   <= 1'b0;
         coef_shadow_q <= '0;
         pattern_q     <= '1;
         x_q           <= '0;
         m_tvalid_q    <= 1'b0;
         m_tdata_q     <= '0;
         m_tuser_q     <= '0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         clear_pend_q <= clear_pend_d;
         tready_q     <= tready_d;
         if (accept_c) begin
            x_q <= s_axis_tdata;
            if (coef_pend_q) pattern_q <= coef_shadow_q;
         end
         // A write in the accepting cycle stays pending for the following beat
         if (coef_wr) begin
            coef_shadow_q <= coef_data;
            coef_pend_q   <= 1'b1;
         end else if (accept_c) begin
            coef_pend_q <= 1'b0;
         end
         if (load_out_c) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= out_data_c;
            m_tuser_q  <= out_user_c;
         end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   // Partial-sum history and per-channel result buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NT; n++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               ps_q[n][c] <= '0;
            end
         end
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            res_y_q[c] <= '0;
            res_f_q[c] <= 1'b0;
         end
      end else if (state_q == PROC) begin
         for (int n = 0; n < NT; n++) begin
            ps_q[n][ch_q] <= ps_next_c[n];
         end
         res_y_q[ch_q] <= y_out_c;
         res_f_q[ch_q] <= flag_c;
      end else if (state_q == CLEAR) begin
         for (int n = 0; n < NT; n++) begin
            ps_q[n][ch_q] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_axis_bit_corr_prog.sv
// Randomised scoreboard bench for axis_bit_corr_prog (4 channels, 4 taps).
module tb_axis_bit_corr_prog;

   localparam int N  = 4;
   localparam int SW = 8;
   localparam int L  = 4;
   localparam int AW = 12;
   localparam int OW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [N*SW-1:0]   s_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [N*OW-1:0]   m_axis_tdata;
   logic [N-1:0]      m_axis_tuser;
   logic              coef_wr;
   logic [L-1:0]      coef_data;
   logic [AW-1:0]     threshold;
   logic              clear;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   axis_bit_corr_prog #(
      .NUM_CHANNELS(N), .SAMPLE_WIDTH(SW), .CORR_LENGTH(L),
      .ADDER_WIDTH(AW), .OUT_WIDTH(OW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .coef_wr(coef_wr), .coef_data(coef_data), .threshold(threshold), .clear(clear)
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference model (beat-level history) ----------------
   int            hx [L][N];      // hx[k][c] = sample of channel c, k beats ago
   logic [L-1:0]  hh [L];         // pattern active when that beat was accepted
   logic [L-1:0]  m_act, m_pend_v;
   bit            m_pend, m_clr;
   logic [N*OW-1:0] q_data [$];
   logic [N-1:0]    q_user [$];
   bit              stall_prev;
   logic [N*OW+N-1:0] held;

   task automatic model_reset();
      for (int k = 0; k < L; k++) begin
         hh[k] = '1;
         for (int c = 0; c < N; c++) hx[k][c] = 0;
      end
      m_act = '1; m_pend_v = '0; m_pend = 0; m_clr = 0;
      q_data.delete(); q_user.delete();
      stall_prev = 0;
   endtask

   task automatic model_beat(input logic [N*SW-1:0] d);
      logic [N*OW-1:0]      ed;
      logic [N-1:0]         eu;
      logic signed [SW-1:0] s;
      logic signed [AW-1:0] yw;
      int                   sum, a;
      if (m_clr) begin
         for (int k = 0; k < L; k++) for (int c = 0; c < N; c++) hx[k][c] = 0;
         m_clr = 0;
      end
      if (m_pend) begin m_act = m_pend_v; m_pend = 0; end
      for (int k = L - 1; k > 0; k--) begin
         hh[k] = hh[k-1];
         for (int c = 0; c < N; c++) hx[k][c] = hx[k-1][c];
      end
      hh[0] = m_act;
      for (int c = 0; c < N; c++) begin
         s = d[c*SW +: SW];
         hx[0][c] = int'(s);
      end
      for (int c = 0; c < N; c++) begin
         sum = 0;
         for (int k = 0; k < L; k++) sum += hh[k][k] ? hx[k][c] : -hx[k][c];
         yw = AW'(sum);
         ed[c*OW +: OW] = OW'(yw);
         a = int'(yw);
         if (a < 0) a = -a;
         eu[c] = (a >= int'(threshold));
      end
      q_data.push_back(ed);
      q_user.push_back(eu);
   endtask

   // Monitor + model: evaluated mid-cycle, describing the upcoming rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_axis_tvalid) begin
            if (m_axis_tready) begin
               if (q_data.size() == 0) begin
                  check("spurious_output", m_axis_tvalid, 1'b0);
               end else begin
                  check("out_tdata", m_axis_tdata, q_data.pop_front());
                  check("out_tuser", m_axis_tuser, q_user.pop_front());
               end
               stall_prev = 0;
            end else begin
               if (stall_prev) check("stall_stable", {m_axis_tuser, m_axis_tdata}, held);
               held       = {m_axis_tuser, m_axis_tdata};
               stall_prev = 1;
            end
         end else begin
            stall_prev = 0;
         end
         if (s_axis_tvalid && s_axis_tready) model_beat(s_axis_tdata);
         if (coef_wr) begin m_pend_v = coef_data; m_pend = 1; end
         if (clear) m_clr = 1;
      end
   end

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic send_beat(input logic [N*SW-1:0] d);
      int cyc = 0;
      bit done = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      while (!done && cyc < 200) begin
         @(negedge clk);
         if (s_axis_tready) done = 1;
         @(posedge clk); #1;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      if (!done) check("accept_timeout", done, 1'b1);
   endtask

   task automatic pulse_coef(input logic [L-1:0] v);
      coef_wr = 1'b1; coef_data = v;
      @(posedge clk); #1;
      coef_wr = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while ((q_data.size() != 0 || m_axis_tvalid) && cyc < 300) begin
         @(posedge clk); cyc++;
      end
      #1;
      check("drain_empty", q_data.size(), 0);
   endtask

   task automatic wait_ready();
      int cyc = 0;
      while (!s_axis_tready && cyc < 100) begin
         @(posedge clk); cyc++;
      end
      #1;
      check("ready_back", s_axis_tready, 1'b1);
   endtask

   bit rnd_done;
   int lat, lowcnt;

   initial begin
      rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
      coef_wr = 1'b0; coef_data = '0; threshold = AW'(3); clear = 1'b0;

      // Reset and defaults
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("tready_in_reset", s_axis_tready, 1'b0);
      check("tvalid_in_reset", m_axis_tvalid, 1'b0);
      check("tdata_in_reset",  m_axis_tdata, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check("tready_after_rst", s_axis_tready, 1'b1);
      check("tvalid_after_rst", m_axis_tvalid, 1'b0);
      @(posedge clk); #1;

      // Moving sum with the default all-ones pattern: 1,2,3,4,4
      repeat (5) send_beat({N{8'h01}});
      drain();

      // Alternating pattern, impulse response and latency
      pulse_clear();
      wait_ready();
      pulse_coef(4'b0101);
      send_beat({24'h0, 8'd5});
      lat = 0;
      @(negedge clk);
      while (!m_axis_tvalid && lat < 20) begin @(negedge clk); lat++; end
      check("latency", lat, N);
      @(posedge clk); #1;
      repeat (4) send_beat('0);
      drain();

      // Backpressure: one result parked, one beat stuck in HOLD
      m_axis_tready = 1'b0;
      send_beat($urandom);
      send_beat($urandom);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("hold_tready_low", s_axis_tready, 1'b0);
      check("hold_tvalid_high", m_axis_tvalid, 1'b1);
      @(posedge clk); #1 m_axis_tready = 1'b1;
      send_beat($urandom);
      drain();

      // Clear during PROC: in-flight beat keeps old history; N proc + 1 idle + N sweep
      repeat (3) send_beat($urandom | 32'h01010101);
      send_beat($urandom);
      clear  = 1'b1;
      lowcnt = 0;
      @(negedge clk);
      if (!s_axis_tready) lowcnt++;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      while (!s_axis_tready && lowcnt < 40) begin lowcnt++; @(negedge clk); end
      check("clear_ready_low_cycles", lowcnt, 2*N + 1);
      @(posedge clk); #1;
      send_beat($urandom);
      drain();

      // Random stream with mid-stream pattern writes and random backpressure
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               send_beat($urandom);
               if ($urandom_range(1) == 1) pulse_coef(L'($urandom));
               repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               m_axis_tready = ($urandom_range(3) != 0);
            end
            m_axis_tready = 1'b1;
         end
      join
      drain();

      // Threshold at the extreme: four taps of -128 gives -512
      pulse_clear();
      wait_ready();
      pulse_coef(4'hF);
      threshold = AW'(512);
      repeat (4) send_beat({N{8'h80}});
      drain();
      threshold = AW'(513);
      send_beat({N{8'h80}});
      drain();

      // Reset mid-operation discards the in-flight beat
      send_beat($urandom);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_tready", s_axis_tready, 1'b0);
      check("midrst_tvalid", m_axis_tvalid, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (N + 3) @(negedge clk);
      check("midrst_no_output", m_axis_tvalid, 1'b0);
      check("midrst_tready_back", s_axis_tready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
